// File: rtl/mem_responder.sv
// Data-memory responder: single-outstanding valid/ready load/store slave with fixed latency.
// Define MEM_ACCESS_CNT_EN to add saturating successful-access counters rd_cnt/wr_cnt.
module mem_responder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [63:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam int unsigned Words     = 1 << DEPTH_LOG2;
  localparam logic [63:0] SpanBytes = 64'd8 << DEPTH_LOG2;
  localparam logic [3:0]  CntLoad   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        wen_q;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic [63:0] wdata_q;

  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem_q [Words];

  logic                  accept, exec, use_in;
  logic                  acc_wen;
  logic [63:0]           acc_addr, acc_wdata;
  logic [1:0]            acc_size;
  logic [63:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [2:0]            lane;
  logic                  oor, mis, acc_err;
  logic [63:0]           word, load_data, size_mask, bit_mask, store_data, new_word;
  logic [7:0]            byte_en_base, byte_en;

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign accept = req_ready & req_valid;
  // The access runs on the edge that enters StResp; with LATENCY==1 that is the accept edge,
  // so the request is taken straight from the inputs rather than the latched copy.
  assign exec   = ((LATENCY == 1) && accept) || ((state_q == StWait) && (cnt_q == 4'd0));
  assign use_in = (state_q == StIdle);

  assign acc_wen   = use_in ? req_wen   : wen_q;
  assign acc_addr  = use_in ? req_addr  : addr_q;
  assign acc_size  = use_in ? req_size  : size_q;
  assign acc_wdata = use_in ? req_wdata : wdata_q;

  always_comb begin
    off          = acc_addr - BASE_ADDR;
    idx          = off[DEPTH_LOG2+2:3];
    lane         = off[2:0];
    oor          = (acc_addr < BASE_ADDR) || (off >= SpanBytes);
    mis          = 1'b0;
    size_mask    = '1;
    byte_en_base = 8'hFF;
    unique case (acc_size)
      2'd0: begin
        mis          = 1'b0;
        size_mask    = 64'h0000_0000_0000_00FF;
        byte_en_base = 8'h01;
      end
      2'd1: begin
        mis          = off[0];
        size_mask    = 64'h0000_0000_0000_FFFF;
        byte_en_base = 8'h03;
      end
      2'd2: begin
        mis          = |off[1:0];
        size_mask    = 64'h0000_0000_FFFF_FFFF;
        byte_en_base = 8'h0F;
      end
      2'd3: begin
        mis          = |off[2:0];
        size_mask    = 64'hFFFF_FFFF_FFFF_FFFF;
        byte_en_base = 8'hFF;
      end
    endcase
    acc_err = oor | mis;

    word      = mem_q[idx];
    load_data = (word >> {lane, 3'b000}) & size_mask;

    byte_en = byte_en_base << lane;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_en[i]}};
    end
    store_data = acc_wdata << {lane, 3'b000};
    new_word   = (word & ~bit_mask) | (store_data & bit_mask);
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (exec && acc_wen && !acc_err) begin
      mem_q[idx] <= new_word;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      size_q  <= req_size;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (exec) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_wen) ? 64'd0 : load_data;
      end
    end
  end

`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;
  logic        good_hs;

  // wen_q is stable throughout StResp, so it identifies the completing access.
  assign good_hs = resp_valid & resp_ready & ~err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (good_hs) begin
      if (wen_q) begin
        if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
      end else begin
        if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule
